gray_ptr_sync: RTL and testbench

- Parametrised multi-stage synchroniser for Gray-coded FIFO pointers crossing into the `clk` domain.
- Generalises the fixed 2-flop pointer synchroniser:
  - configurable width and stage count;
  - registered Gray-to-binary output;
  - change pulse;
  - Gray-violation detection;
  - stability indication.
- Sits in the read (or write) domain of the async FIFO and feeds the full/empty comparators.

---
 rtl/gray_ptr_sync_if.sv | 23 ++
 rtl/gray_ptr_sync.sv | 135 +++++++++++++
 tb/tb_gray_ptr_sync.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_ptr_sync_if.sv
// Pointer-synchroniser bus: source-side Gray pointer and error clear in,
// synchronised pointer, binary value and status flags out.
interface gray_ptr_sync_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_gray;
  logic             err_clr;
  logic [WIDTH-1:0] out_gray;
  logic [WIDTH-1:0] out_bin;
  logic             changed;
  logic             gray_err;
  logic             stable;

  modport master (
    output in_gray, err_clr,
    input  out_gray, out_bin, changed, gray_err, stable
  );

  modport slave (
    input  in_gray, err_clr,
    output out_gray, out_bin, changed, gray_err, stable
  );
endinterface

// File: rtl/gray_ptr_sync.sv
// Multi-stage synchroniser for Gray-coded FIFO pointers entering the clk domain,
// with registered binary conversion, change pulse, Gray-violation flag and stability flag.
module gray_ptr_sync #(
  parameter int WIDTH         = 8,
  parameter int STAGES        = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  gray_ptr_sync_if.slave     sync_if
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("gray_ptr_sync: STAGES must be 2..4");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("gray_ptr_sync: WIDTH must be >= 2");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("gray_ptr_sync: STABLE_CYCLES must be 1..255");
  end

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [2:0] PRIME_MAX  = 3'(STAGES + 1);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit of d is set.
  function automatic logic multi_bit(input logic [WIDTH-1:0] d);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      multi = multi | (seen & d[i]);
      seen  = seen | d[i];
    end
    return multi;
  endfunction

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             changed_q, changed_d;
  logic             err_q, err_d;
  logic [7:0]       stab_cnt_q, stab_cnt_d;
  logic             stable_q, stable_d;
  logic [2:0]       prime_cnt_q, prime_cnt_d;
  logic [WIDTH-1:0] out_gray_s;
  logic [WIDTH-1:0] delta_s;
  logic             primed_s;
  logic             moved_s;

  assign out_gray_s = sync_q[STAGES-1];
  assign delta_s    = out_gray_s ^ prev_q;
  assign moved_s    = (delta_s != {WIDTH{1'b0}});
  assign primed_s   = (prime_cnt_q == PRIME_MAX);

  // Next-state logic for the sync chain, post-stage and status flags.
  always_comb begin
    sync_d[0] = sync_if.in_gray;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    prev_d    = out_gray_s;
    bin_d     = gray2bin(out_gray_s);
    changed_d = moved_s & primed_s;

    if (primed_s) begin
      prime_cnt_d = prime_cnt_q;
    end else begin
      prime_cnt_d = prime_cnt_q + 3'd1;
    end

    // A violation on the same edge as a clear keeps the flag set.
    if (primed_s && multi_bit(delta_s)) begin
      err_d = 1'b1;
    end else if (sync_if.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    if (!primed_s || moved_s) begin
      stab_cnt_d = 8'd0;
    end else if (stab_cnt_q == STABLE_MAX) begin
      stab_cnt_d = stab_cnt_q;
    end else begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end
    stable_d = (stab_cnt_d == STABLE_MAX);
  end

  // State registers, cleared asynchronously by rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= {WIDTH{1'b0}};
      end
      prev_q      <= {WIDTH{1'b0}};
      bin_q       <= {WIDTH{1'b0}};
      changed_q   <= 1'b0;
      err_q       <= 1'b0;
      stab_cnt_q  <= 8'd0;
      stable_q    <= 1'b0;
      prime_cnt_q <= 3'd0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      prev_q      <= prev_d;
      bin_q       <= bin_d;
      changed_q   <= changed_d;
      err_q       <= err_d;
      stab_cnt_q  <= stab_cnt_d;
      stable_q    <= stable_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  assign sync_if.out_gray = out_gray_s;
  assign sync_if.out_bin  = bin_q;
  assign sync_if.changed  = changed_q;
  assign sync_if.gray_err = err_q;
  assign sync_if.stable   = stable_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: a WIDTH=4/STAGES=2 and a WIDTH=8/STAGES=3 instance,
// checked every cycle against an input-history model plus directed literal checks.
module tb_gray_ptr_sync;
  localparam int SC   = 4;
  localparam int MAXE = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gray_ptr_sync_if #(.WIDTH(4)) ifa ();
  gray_ptr_sync_if #(.WIDTH(8)) ifb ();

  gray_ptr_sync #(.WIDTH(4), .STAGES(2), .STABLE_CYCLES(SC)) dut_a (
    .clk(clk), .rst(rst), .sync_if(ifa)
  );
  gray_ptr_sync #(.WIDTH(8), .STAGES(3), .STABLE_CYCLES(SC)) dut_b (
    .clk(clk), .rst(rst), .sync_if(ifb)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   started = 1'b0;
  int   nedge   = 0;
  logic [7:0] hin   [2][MAXE];
  logic       err_m [2];

  // Model: out_gray after edge m is the input sampled STAGES-1 edges earlier.
  function automatic int stages(input int s);
    return (s != 0) ? 3 : 2;
  endfunction

  function automatic logic [7:0] og(input int s, input int m);
    int k;
    k = m - stages(s) + 1;
    if (k < 1) return 8'h00;
    return hin[s][k];
  endfunction

  function automatic bit pr(input int s, input int k);
    return k >= stages(s) + 1;
  endfunction

  function automatic logic [7:0] inv_gray(input logic [7:0] g);
    for (int i = 0; i < 256; i++) begin
      if (8'(i ^ (i >> 1)) == g) return 8'(i);
    end
    return 8'h00;
  endfunction

  function automatic bit exp_changed(input int s, input int n);
    return (n >= 1) && pr(s, n - 1) && (og(s, n - 1) != og(s, n - 2));
  endfunction

  function automatic bit exp_stable(input int s, input int n);
    if (n < SC) return 1'b0;
    for (int m = n - SC + 1; m <= n; m++) begin
      if (!pr(s, m - 1) || (og(s, m - 1) != og(s, m - 2))) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      nedge    = 0;
      err_m[0] = 1'b0;
      err_m[1] = 1'b0;
    end else if (nedge < MAXE - 1) begin
      nedge++;
      hin[0][nedge] = {4'h0, ifa.in_gray};
      hin[1][nedge] = ifb.in_gray;
      for (int s = 0; s < 2; s++) begin
        if (pr(s, nedge - 1) && ($countones(og(s, nedge - 1) ^ og(s, nedge - 2)) > 1))
          err_m[s] = 1'b1;
        else if ((s == 0) ? ifa.err_clr : ifb.err_clr)
          err_m[s] = 1'b0;
      end
    end
  end

  task automatic compare_dut(input int s);
    logic [7:0] a_gray, a_bin;
    logic       a_chg, a_err, a_stb;
    if (s == 0) begin
      a_gray = {4'h0, ifa.out_gray}; a_bin = {4'h0, ifa.out_bin};
      a_chg = ifa.changed; a_err = ifa.gray_err; a_stb = ifa.stable;
    end else begin
      a_gray = ifb.out_gray; a_bin = ifb.out_bin;
      a_chg = ifb.changed; a_err = ifb.gray_err; a_stb = ifb.stable;
    end
    if (!rst) begin
      check(s ? "B.rst_gray" : "A.rst_gray", a_gray, 8'h00);
      check(s ? "B.rst_bin"  : "A.rst_bin",  a_bin,  8'h00);
      check(s ? "B.rst_chg"  : "A.rst_chg",  {7'd0, a_chg}, 8'h00);
      check(s ? "B.rst_err"  : "A.rst_err",  {7'd0, a_err}, 8'h00);
      check(s ? "B.rst_stb"  : "A.rst_stb",  {7'd0, a_stb}, 8'h00);
    end else begin
      check(s ? "B.out_gray" : "A.out_gray", a_gray, og(s, nedge));
      check(s ? "B.out_bin"  : "A.out_bin",  a_bin,  inv_gray(og(s, nedge - 1)));
      check(s ? "B.changed"  : "A.changed",  {7'd0, a_chg}, {7'd0, exp_changed(s, nedge)});
      check(s ? "B.gray_err" : "A.gray_err", {7'd0, a_err}, {7'd0, err_m[s]});
      check(s ? "B.stable"   : "A.stable",   {7'd0, a_stb}, {7'd0, exp_stable(s, nedge)});
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      compare_dut(0);
      compare_dut(1);
    end
  end

  task automatic tick(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [3:0] gseq [17];

  initial begin
    gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
             4'b0000};
    ifa.in_gray = 4'h0; ifa.err_clr = 1'b0;
    ifb.in_gray = 8'h00; ifb.err_clr = 1'b0;
    rst = 1'b0;
    tick(2);
    started = 1'b1;
    check("reset A.out_bin", {4'h0, ifa.out_bin}, 8'h00);
    check("reset B.stable", {7'd0, ifb.stable}, 8'h00);

    // Single step 0000 -> 0001 after priming
    rst = 1'b1;
    tick(6);
    ifa.in_gray = 4'b0001;
    tick(1);
    check("t1 gray N+1", {4'h0, ifa.out_gray}, 8'h00);
    tick(1);
    check("t1 gray N+2", {4'h0, ifa.out_gray}, 8'h01);
    check("t1 bin N+2", {4'h0, ifa.out_bin}, 8'h00);
    tick(1);
    check("t1 bin N+3", {4'h0, ifa.out_bin}, 8'h01);
    check("t1 chg N+3", {7'd0, ifa.changed}, 8'h01);
    check("t1 err N+3", {7'd0, ifa.gray_err}, 8'h00);
    tick(1);
    check("t1 chg N+4", {7'd0, ifa.changed}, 8'h00);

    // Full Gray walk with wrap
    for (int i = 0; i < 17; i++) begin
      ifa.in_gray = gseq[i];
      tick(1);
    end
    tick(1);
    check("t2 bin max", {4'h0, ifa.out_bin}, 8'h0f);
    tick(1);
    check("t2 bin wrap", {4'h0, ifa.out_bin}, 8'h00);
    check("t2 chg wrap", {7'd0, ifa.changed}, 8'h01);
    check("t2 err wrap", {7'd0, ifa.gray_err}, 8'h00);
    tick(3);

    // Multi-bit jump, sticky error, clear, set-wins
    ifa.in_gray = 4'b0001;
    tick(6);
    ifa.in_gray = 4'b0110;
    tick(3);
    check("t3 err set", {7'd0, ifa.gray_err}, 8'h01);
    check("t3 chg set", {7'd0, ifa.changed}, 8'h01);
    tick(2);
    check("t3 err sticky", {7'd0, ifa.gray_err}, 8'h01);
    ifa.err_clr = 1'b1;
    tick(1);
    ifa.err_clr = 1'b0;
    check("t3 err clr", {7'd0, ifa.gray_err}, 8'h00);
    tick(1);
    ifa.in_gray = 4'b0001;
    tick(2);
    ifa.err_clr = 1'b1;
    tick(1);
    ifa.err_clr = 1'b0;
    check("t3 set wins", {7'd0, ifa.gray_err}, 8'h01);
    ifa.err_clr = 1'b1;
    tick(1);
    ifa.err_clr = 1'b0;
    tick(2);

    // Nonzero pointer held through reset release
    rst = 1'b0;
    ifa.in_gray = 4'b0101;
    tick(2);
    rst = 1'b1;
    tick(3);
    check("t4 bin", {4'h0, ifa.out_bin}, 8'h06);
    check("t4 chg", {7'd0, ifa.changed}, 8'h00);
    check("t4 err", {7'd0, ifa.gray_err}, 8'h00);
    tick(3);
    check("t4 stable early", {7'd0, ifa.stable}, 8'h00);
    tick(1);
    check("t4 stable", {7'd0, ifa.stable}, 8'h01);

    // Asynchronous reset mid-cycle
    ifa.in_gray = 4'b0100;
    tick(5);
    check("t5 bin before", {4'h0, ifa.out_bin}, 8'h07);
    #1;
    rst = 1'b0;
    #1;
    check("t5 async gray", {4'h0, ifa.out_gray}, 8'h00);
    check("t5 async bin", {4'h0, ifa.out_bin}, 8'h00);
    check("t5 async stable", {7'd0, ifa.stable}, 8'h00);
    ifa.in_gray = 4'b0000;
    tick(2);
    rst = 1'b1;
    tick(6);
    check("t5 chg after", {7'd0, ifa.changed}, 8'h00);
    check("t5 bin after", {4'h0, ifa.out_bin}, 8'h00);

    // Three-stage instance latency and stability
    tick(4);
    check("t6 stable pre", {7'd0, ifb.stable}, 8'h01);
    ifb.in_gray = 8'h01;
    tick(2);
    check("t6 gray E2", ifb.out_gray, 8'h00);
    tick(1);
    check("t6 gray E3", ifb.out_gray, 8'h01);
    check("t6 bin E3", ifb.out_bin, 8'h00);
    tick(1);
    check("t6 bin E4", ifb.out_bin, 8'h01);
    check("t6 chg E4", {7'd0, ifb.changed}, 8'h01);
    check("t6 stable drop", {7'd0, ifb.stable}, 8'h00);
    tick(3);
    check("t6 stable E7", {7'd0, ifb.stable}, 8'h00);
    tick(1);
    check("t6 stable E8", {7'd0, ifb.stable}, 8'h01);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
